// File: rtl/alu_rr_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcodes, FSM states and
// the registered response bundle.
package alu_rr_arbiter_pkg;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_SLL    = 5'd4;
  localparam logic [4:0] ALU_SRA    = 5'd5;
  localparam logic [4:0] ALU_OP_MAX = ALU_SRA;

  // IDLE: response register empty; FULL: it holds the owner's result
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] result;
    logic        ne;
    logic        lt;
    logic        ovf;
    logic        err;
  } alu_rsp_t;

  function automatic logic op_legal(input logic [4:0] op);
    return (op <= ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_alu.sv
// Combinational 32-bit ALU: add/sub/and/or/sll/sra plus compare flags taken
// from the subtract path. Illegal opcodes yield zero result/flags and err.
module alu_rr_arbiter_alu
  import alu_rr_arbiter_pkg::*;
(
  input  logic [4:0]  i_opcode,
  input  logic [4:0]  i_shamt,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output alu_rsp_t    o_rsp
);

  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic        w_add_ovf;
  logic        w_sub_ovf;
  logic        w_legal;

  assign w_sum     = i_a + i_b;
  assign w_diff    = i_a - i_b;
  assign w_add_ovf = (i_a[31] == i_b[31]) && (w_sum[31]  != i_a[31]);
  assign w_sub_ovf = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);
  assign w_legal   = op_legal(i_opcode);

  // Result/flag selection; compare flags always come from the subtractor
  always_comb begin
    o_rsp = '0;
    if (w_legal) begin
      o_rsp.ne = (w_diff != '0);
      o_rsp.lt = w_diff[31] ^ w_sub_ovf;
      case (i_opcode)
        ALU_ADD: begin
          o_rsp.result = w_sum;
          o_rsp.ovf    = w_add_ovf;
        end
        ALU_SUB: begin
          o_rsp.result = w_diff;
          o_rsp.ovf    = w_sub_ovf;
        end
        ALU_AND: o_rsp.result = i_a & i_b;
        ALU_OR:  o_rsp.result = i_a | i_b;
        ALU_SLL: o_rsp.result = i_a << i_shamt;
        ALU_SRA: o_rsp.result = 32'($signed(i_a) >>> i_shamt);
        default: o_rsp.result = '0;
      endcase
    end else begin
      o_rsp.err = 1'b1;
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-port round-robin front end for a shared ALU. One operation in flight;
// the result sits in a response register until its owner takes it, and a new
// grant may be issued in the same cycle the response is consumed.
module alu_rr_arbiter
  import alu_rr_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter bit          RR_INIT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][4:0]  req_opcode,
  input  logic [1:0][4:0]  req_shamt,
  input  logic [1:0][31:0] req_a,
  input  logic [1:0][31:0] req_b,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_ne,
  output logic             rsp_lt,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  state_t           r_state;
  logic             r_owner;
  logic             r_prio;
  logic [1:0]       r_rsp_valid;
  alu_rsp_t         r_rsp;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_rsp_taken;
  logic             w_slot_free;
  logic             w_gnt_vld;
  logic             w_gnt_port;
  alu_rsp_t         w_alu_rsp;

  // Slot is free when empty or when the owner drains it this cycle; reset
  // gating keeps req_ready low while reset is held
  always_comb begin
    w_rsp_taken = (r_state == ST_FULL) && r_rsp_valid[r_owner] && rsp_ready[r_owner];
    w_slot_free = reset && ((r_state == ST_IDLE) || w_rsp_taken);
    w_gnt_vld   = w_slot_free && (req_valid != 2'b00);
    w_gnt_port  = (req_valid == 2'b11) ? r_prio : req_valid[1];
    req_ready   = '0;
    if (w_gnt_vld) begin
      req_ready[w_gnt_port] = 1'b1;
    end
  end

  alu_rr_arbiter_alu u_alu (
    .i_opcode (req_opcode[w_gnt_port]),
    .i_shamt  (req_shamt[w_gnt_port]),
    .i_a      (req_a[w_gnt_port]),
    .i_b      (req_b[w_gnt_port]),
    .o_rsp    (w_alu_rsp)
  );

  // Slot FSM, response register, priority rotation and grant counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= 1'b0;
      r_prio      <= RR_INIT;
      r_rsp_valid <= '0;
      r_rsp       <= '0;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
    end else begin
      if (w_gnt_vld) begin
        r_state     <= ST_FULL;
        r_owner     <= w_gnt_port;
        r_prio      <= ~w_gnt_port;
        r_rsp_valid <= w_gnt_port ? 2'b10 : 2'b01;
        r_rsp       <= w_alu_rsp;
        if (!w_gnt_port && (r_cnt0 != '1)) begin
          r_cnt0 <= r_cnt0 + 1'b1;
        end
        if (w_gnt_port && (r_cnt1 != '1)) begin
          r_cnt1 <= r_cnt1 + 1'b1;
        end
      end else if (w_rsp_taken) begin
        r_state     <= ST_IDLE;
        r_rsp_valid <= '0;
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp.result;
  assign rsp_ne     = r_rsp.ne;
  assign rsp_lt     = r_rsp.lt;
  assign rsp_ovf    = r_rsp.ovf;
  assign rsp_err    = r_rsp.err;
  assign gnt_cnt0   = r_cnt0;
  assign gnt_cnt1   = r_cnt1;

endmodule
